long_mul_sequencer: RTL and testbench

//  Multi-cycle controller for 32x32->64 long multiply (UMULL/SMULL) in the single-cycle ARM core.

---
 rtl/long_mul_sequencer_pkg.sv | 15 +
 rtl/long_mul_sequencer_mul_shift_add_dp.sv | 80 ++++++++
 rtl/long_mul_sequencer.sv | 117 +++++++++++
 tb/tb_long_mul_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/long_mul_sequencer_pkg.sv
// Shared definitions for the long-multiply sequencer: default widths and FSM state encoding.
package long_mul_sequencer_pkg;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned REG_ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StFix,
        StWrLo,
        StWrHi
    } state_e;

endpackage

// File: rtl/long_mul_sequencer_mul_shift_add_dp.sv
// Shift-add datapath for the long multiply: operand magnitudes, sign flag, accumulator and
// step counter. Sequenced by load/step/negate strobes from the controlling FSM.
module mul_shift_add_dp
    import long_mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               negate_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   src_a_i,
    input  logic [WIDTH-1:0]   src_b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mcand_ext;

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    always_comb begin
        abs_a = (signed_i && src_a_i[WIDTH-1]) ? (~src_a_i + WIDTH'(1)) : src_a_i;
        abs_b = (signed_i && src_b_i[WIDTH-1]) ? (~src_b_i + WIDTH'(1)) : src_b_i;
        mcand_ext = {{WIDTH{1'b0}}, mcand_q};
    end

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        count_d = count_q;
        neg_d   = neg_q;
        if (load_i) begin
            mcand_d = abs_a;
            mplr_d  = abs_b;
            neg_d   = signed_i & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
            acc_d   = '0;
            count_d = '0;
        end else if (step_i) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + (mcand_ext << count_q);
            end
            mplr_d  = mplr_q >> 1;
            count_d = count_q + CNT_W'(1);
        end else if (negate_i && neg_q) begin
            acc_d = ~acc_q + (2 * WIDTH)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            neg_q   <= neg_d;
        end
    end

    assign last_o = (count_q == CNT_W'(WIDTH - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/long_mul_sequencer.sv
// Multi-cycle UMULL/SMULL sequencer: stalls the core while the shift-add loop runs, then
// drives the register-file write port for the low word and then the high word.
module long_mul_sequencer
    import long_mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic                  Signed,
    input  logic [WIDTH-1:0]      SrcA,
    input  logic [WIDTH-1:0]      SrcB,
    input  logic [REG_ADDR_W-1:0] RdLo,
    input  logic [REG_ADDR_W-1:0] RdHi,
    output logic                  Stall,
    output logic                  Busy,
    output logic                  MulWE,
    output logic [REG_ADDR_W-1:0] MulWA,
    output logic [WIDTH-1:0]      MulWD,
    output logic                  Done
);

    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] rd_lo_q, rd_lo_d;
    logic [REG_ADDR_W-1:0] rd_hi_q, rd_hi_d;

    logic               load, step, negate, last;
    logic [2*WIDTH-1:0] acc;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .negate_i (negate),
        .signed_i (Signed),
        .src_a_i  (SrcA),
        .src_b_i  (SrcB),
        .last_o   (last),
        .acc_o    (acc)
    );

    always_comb begin
        state_d = state_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        load    = 1'b0;
        step    = 1'b0;
        negate  = 1'b0;
        Busy    = (state_q != StIdle);
        Stall   = 1'b0;
        MulWE   = 1'b0;
        MulWA   = '0;
        MulWD   = '0;
        Done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                Stall = Start;
                if (Start) begin
                    load    = 1'b1;
                    rd_lo_d = RdLo;
                    rd_hi_d = RdHi;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                Stall = 1'b1;
                step  = 1'b1;
                if (last) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                Stall   = 1'b1;
                negate  = 1'b1;
                state_d = StWrLo;
            end
            StWrLo: begin
                Stall   = 1'b1;
                MulWE   = 1'b1;
                MulWA   = rd_lo_q;
                MulWD   = acc[WIDTH-1:0];
                state_d = StWrHi;
            end
            // Stall drops here so the core retires the multiply on this edge.
            StWrHi: begin
                MulWE   = 1'b1;
                MulWA   = rd_hi_q;
                MulWD   = acc[2*WIDTH-1:WIDTH];
                Done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Keep the core free while reset is held, even if Start is asserted in IDLE.
        if (reset) begin
            Stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rd_lo_q <= '0;
            rd_hi_q <= '0;
        end else begin
            state_q <= state_d;
            rd_lo_q <= rd_lo_d;
            rd_hi_q <= rd_hi_d;
        end
    end

endmodule

// File: tb/tb_long_mul_sequencer.sv
// Scoreboard bench for long_mul_sequencer: stimulus pushes expected register writes, a
// negedge monitor pops and compares them along with Stall/Busy timing.
module tb_long_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start, Signed;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  RdLo, RdHi;
    logic        Stall, Busy, MulWE, Done;
    logic [3:0]  MulWA;
    logic [31:0] MulWD;

    long_mul_sequencer #(
        .WIDTH      (32),
        .REG_ADDR_W (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Signed (Signed),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .RdLo   (RdLo),
        .RdHi   (RdHi),
        .Stall  (Stall),
        .Busy   (Busy),
        .MulWE  (MulWE),
        .MulWA  (MulWA),
        .MulWD  (MulWD),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        bit          done;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    int          cyc = 0;
    int          op_start = -1000;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    logic [31:0] rf[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Monitor: writes against the scoreboard, handshake timing against the open operation.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("stall", Stall, (cyc >= op_start && cyc <= op_start + 34));
            chk("busy", Busy, (cyc >= op_start + 1 && cyc <= op_start + 35));
            if (MulWE) begin
                rf[MulWA] = MulWD;
                if (exp_q.size() == 0) begin
                    chk("spurious_write", MulWE, 1'b0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", MulWA, e.addr);
                    chk("wr_data", MulWD, e.data);
                    chk("wr_done", Done, e.done);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_port", {Done, MulWA, MulWD}, '0);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rlo, input logic [3:0] rhi, input bit hold);
        logic [63:0] p;
        p = ref_mul(sgn, a, b);
        @(posedge clk); #1;
        Signed = sgn; SrcA = a; SrcB = b; RdLo = rlo; RdHi = rhi; Start = 1'b1;
        op_start = cyc;
        exp_q.push_back('{addr: rlo, data: p[31:0], done: 1'b0, cyc: cyc + 34});
        exp_q.push_back('{addr: rhi, data: p[63:32], done: 1'b1, cyc: cyc + 35});
        @(posedge clk); #1;
        SrcA = $urandom; SrcB = $urandom; Signed = 1'($urandom);
        RdLo = 4'($urandom); RdHi = 4'($urandom);
        if (!hold) Start = 1'b0;
        else begin
            repeat (35) @(posedge clk);
            #1 Start = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] p;
        reset = 1'b1; Start = 1'b0; Signed = 1'b0;
        SrcA = '0; SrcB = '0; RdLo = '0; RdHi = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {Stall, Busy, MulWE, Done, MulWA, MulWD}, '0);
        reset = 1'b0;
        mon_en = 1'b1;

        issue(1'b0, 32'd5, 32'd4, 4'd1, 4'd2, 1'b0);                    drain();
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 4'd5, 1'b0);    drain();
        issue(1'b0, 32'h1C8C_FC00, 32'h0000_000D, 4'd6, 4'd7, 1'b0);    drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 4'd8, 4'd9, 1'b0);    drain();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd10, 4'd11, 1'b0);  drain();

        // Start held through WR_HI, same destination for both halves.
        issue(1'b1, 32'h1234_5678, 32'hF000_0001, 4'd3, 4'd3, 1'b1);
        drain();
        p = ref_mul(1'b1, 32'h1234_5678, 32'hF000_0001);
        chk("rdlo_eq_rdhi", rf[3], p[63:32]);

        // Abort in CALC cycle 10.
        @(posedge clk); #1;
        Signed = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0BAD_F00D;
        RdLo = 4'd12; RdHi = 4'd13; Start = 1'b1;
        op_start = cyc;
        @(posedge clk); #1 Start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_outputs", {Busy, Stall, MulWE}, 3'b000);
        op_start = -1000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        issue(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'd12, 4'd13, 1'b0);  drain();

        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), pick(), pick(), 4'($urandom), 4'($urandom), 1'b0);
            drain();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
